// File: rtl/lcb_mem_arbiter.sv
// Round-robin req/grant arbiter for the shared ping-pong orbit-word memory port.
// Adds a hold timeout and owner-tagged read return. Optional grant counters: ARB_STATS_EN.
module lcb_mem_arbiter #(
  parameter int unsigned DW       = 12,
  parameter int unsigned AW       = 10,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  output logic [3:0]      grant,
  input  logic [4*DW-1:0] wdata,
  input  logic [4*AW-1:0] waddr,
  input  logic [3:0]      wren,
  input  logic [4*AW-1:0] raddr,
  input  logic [3:0]      rden,
  output logic [DW-1:0]   commWrdOut,
  output logic [AW-1:0]   commWrdAddr,
  output logic            commWren,
  output logic [AW-1:0]   commOldWrdAddr,
  output logic            commOldRdEn,
  input  logic [DW-1:0]   commOldWrd,
  output logic [DW-1:0]   oldWrd,
  output logic [3:0]      rdValid,
  output logic            timeoutPulse,
  output logic [63:0]     grantCnt
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    grant_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_d;
  logic          start_grant;

  logic          rr_found;
  logic [1:0]    rr_pick;
  logic [1:0]    rr_idx;

  logic [RD_LAT-1:0] pipe_vld;
  logic [1:0]        pipe_idx [RD_LAT];
  logic              pipe_busy;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin : rr_search
    rr_found = 1'b0;
    rr_pick  = ptr_q;
    rr_idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      rr_idx = ptr_q + 2'(i);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Entries still in flight after this edge; the last stage leaves on this edge.
  always_comb begin : pipe_drain
    pipe_busy = 1'b0;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
      pipe_busy = pipe_busy | pipe_vld[i];
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    start_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d     = GRANT;
          owner_d     = rr_pick;
          grant_d     = 4'(4'b0001 << rr_pick);
          hold_d      = '0;
          start_grant = 1'b1;
        end
      end
      GRANT: begin
        hold_d = (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + HW'(1);
        // A dropped req wins over a coincident timeout: normal release, no pulse.
        if (!req[owner_q]) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = owner_q + 2'd1;
        end else if (hold_q == HW'(HOLD_MAX - 1)) begin
          state_d   = RELEASE;
          grant_d   = '0;
          ptr_d     = owner_q + 2'd1;
          timeout_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : fsm_reg
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant        <= '0;
      hold_q       <= '0;
      timeoutPulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      grant        <= grant_d;
      hold_q       <= hold_d;
      timeoutPulse <= timeout_d;
    end
  end

  // Owner's port reaches memory combinationally; everything is zero outside GRANT.
  always_comb begin : comm_mux
    commWrdOut     = '0;
    commWrdAddr    = '0;
    commWren       = 1'b0;
    commOldWrdAddr = '0;
    commOldRdEn    = 1'b0;
    if (state_q == GRANT) begin
      commWrdOut     = wdata[32'(owner_q) * DW +: DW];
      commWrdAddr    = waddr[32'(owner_q) * AW +: AW];
      commWren       = wren[owner_q];
      commOldWrdAddr = raddr[32'(owner_q) * AW +: AW];
      commOldRdEn    = rden[owner_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin : rd_pipe
    if (!reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_idx[i] <= '0;
    end else begin
      pipe_vld[0] <= commOldRdEn;
      pipe_idx[0] <= owner_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Tagged read return; oldWrd holds between returns.
  always_ff @(posedge clk or negedge reset) begin : rd_out
    if (!reset) begin
      rdValid <= '0;
      oldWrd  <= '0;
    end else begin
      rdValid <= pipe_vld[RD_LAT-1] ? 4'(4'b0001 << pipe_idx[RD_LAT-1]) : 4'b0000;
      if (pipe_vld[RD_LAT-1]) oldWrd <= commOldWrd;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk or negedge reset) begin : stats
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (start_grant && (cnt_q[rr_pick] != 16'hFFFF)) begin
      cnt_q[rr_pick] <= cnt_q[rr_pick] + 16'd1;
    end
  end

  assign grantCnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  logic stats_unused;
  assign stats_unused = start_grant;
  assign grantCnt     = '0;
`endif

endmodule

// File: tb/tb_lcb_mem_arbiter.sv
// Scoreboard bench for lcb_mem_arbiter: transaction-level reference model, directed
// test-plan sequences, then randomized traffic. Honours ARB_STATS_EN when defined.
module tb_lcb_mem_arbiter;

  localparam int DW       = 12;
  localparam int AW       = 10;
  localparam int RD_LAT   = 2;
  localparam int HOLD_MAX = 255;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk, reset;
  logic [3:0]      req, wren, rden;
  logic [4*DW-1:0] wdata;
  logic [4*AW-1:0] waddr, raddr;
  logic [3:0]      grant, rdValid;
  logic [DW-1:0]   commWrdOut, commOldWrd, oldWrd;
  logic [AW-1:0]   commWrdAddr, commOldWrdAddr;
  logic            commWren, commOldRdEn, timeoutPulse;
  logic [63:0]     grantCnt;

  lcb_mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .wdata(wdata), .waddr(waddr), .wren(wren), .raddr(raddr), .rden(rden),
    .commWrdOut(commWrdOut), .commWrdAddr(commWrdAddr), .commWren(commWren),
    .commOldWrdAddr(commOldWrdAddr), .commOldRdEn(commOldRdEn), .commOldWrd(commOldWrd),
    .oldWrd(oldWrd), .rdValid(rdValid), .timeoutPulse(timeoutPulse), .grantCnt(grantCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int v);
    n_checks++;
    n_fail++;
    $display("FAIL %s: value %0d (cycle %0d)", name, v, cyc);
  endtask

  // Memory environment: read data appears RD_LAT cycles after the enable cycle.
  logic [DW-1:0] env_mem [1<<AW];
  logic [DW-1:0] env_dly [RD_LAT];
  assign commOldWrd = env_dly[RD_LAT-1];

  initial begin
    for (int i = 0; i < (1<<AW); i++) env_mem[i] <= DW'(i * 37 + 5);
    for (int i = 0; i < RD_LAT; i++) env_dly[i] <= '0;
    forever begin
      @(posedge clk);
      env_dly[0] <= commOldRdEn ? env_mem[commOldWrdAddr] : DW'($urandom);
      for (int i = 1; i < RD_LAT; i++) env_dly[i] <= env_dly[i-1];
      if (commWren) env_mem[commWrdAddr] <= commWrdOut;
    end
  end

  // Reference model: who owns the port, when each grant/release happens, what each read returns.
  typedef struct { int cyc; logic [3:0] g; logic to; } gev_t;
  typedef struct { int due; int ch; logic [DW-1:0] data; } rd_t;
  gev_t          evq[$];
  rd_t           rdq[$];
  int            m_owner, m_gedge, m_ptr, m_rel_exit;
  bit            m_rel;
  logic [DW-1:0] model_mem [1<<AW];
  logic [15:0]   m_cnt [4];
  logic [DW-1:0] exp_old;

  task automatic model_reset();
    evq.delete();
    rdq.delete();
    m_owner = -1; m_gedge = 0; m_ptr = 0; m_rel = 1'b0; m_rel_exit = 0;
    exp_old = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
  endtask

  function automatic logic [63:0] exp_cnt();
    return STATS ? {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]} : 64'd0;
  endfunction

  task automatic release_owner(input logic to);
    int last_due;
    last_due = (rdq.size() > 0) ? rdq[rdq.size()-1].due : 0;
    evq.push_back('{cyc, 4'b0000, to});
    m_ptr      = (m_owner + 1) % 4;
    m_rel_exit = (last_due > cyc + 1) ? last_due : cyc + 1;
    m_owner    = -1;
    m_rel      = 1'b1;
  endtask

  // Applies the inputs sampled at edge number cyc.
  task automatic model_step();
    int o;
    if (!reset) return;
    o = m_owner;
    if (o >= 0) begin
      if (rden[o]) rdq.push_back('{cyc + RD_LAT, o, model_mem[raddr[o*AW +: AW]]});
      if (wren[o]) model_mem[waddr[o*AW +: AW]] = wdata[o*DW +: DW];
      if (!req[o]) release_owner(1'b0);
      else if (cyc - m_gedge == HOLD_MAX) release_owner(1'b1);
    end else if (m_rel) begin
      if (cyc >= m_rel_exit) m_rel = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_gedge = cyc;
          evq.push_back('{cyc, 4'(1 << m_owner), 1'b0});
          if (m_cnt[m_owner] != 16'hFFFF) m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; wren = '0; rden = '0; wdata = '0; waddr = '0; raddr = '0;
  endtask

  // Monitor: compares DUT against the model away from the clock edge.
  logic [3:0]  prev_g;
  logic [33:0] exp_comm;
  gev_t        ge;
  rd_t         re;

  initial begin
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_g = '0;
      end else begin
        check("grant_onehot", 64'($countones(grant) <= 1), 64'(1));
        exp_comm = '0;
        if (m_owner >= 0)
          exp_comm = {wren[m_owner], rden[m_owner], wdata[m_owner*DW +: DW],
                      waddr[m_owner*AW +: AW], raddr[m_owner*AW +: AW]};
        check("comm_port", 64'({commWren, commOldRdEn, commWrdOut, commWrdAddr, commOldWrdAddr}),
              64'(exp_comm));
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
          fail_now("grant_event_missing", evq[0].cyc);
          void'(evq.pop_front());
        end
        if (grant != prev_g || timeoutPulse) begin
          if (evq.size() == 0) fail_now("grant_event_unexpected", int'(grant));
          else begin
            ge = evq.pop_front();
            check("grant_event", 64'({32'(cyc), grant, timeoutPulse}), 64'({32'(ge.cyc), ge.g, ge.to}));
          end
        end
        prev_g = grant;
        if (rdValid != '0 || (rdq.size() > 0 && rdq[0].due <= cyc)) begin
          if (rdq.size() == 0) fail_now("read_unexpected", int'(rdValid));
          else begin
            re = rdq.pop_front();
            check("read_return", 64'({32'(cyc), rdValid, oldWrd}),
                  64'({32'(re.due), 4'(1 << re.ch), re.data}));
            exp_old = re.data;
          end
        end else begin
          check("oldwrd_hold", 64'(oldWrd), 64'(exp_old));
        end
        check("grant_cnt", grantCnt, exp_cnt());
      end
    end
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) model_mem[i] = DW'(i * 37 + 5);
    model_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_comm", 64'({commWren, commOldRdEn, commWrdOut, commWrdAddr, commOldWrdAddr}), 64'(0));
    check("rst_oldwrd", 64'(oldWrd), 64'(0));
    check("rst_rdvalid", 64'(rdValid), 64'(0));
    check("rst_timeout", 64'(timeoutPulse), 64'(0));
    check("rst_grantcnt", grantCnt, 64'(0));
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Single requester read-modify-write on address 0x05.
    req = 4'b0001;
    tick();
    rden[0] = 1'b1; raddr[0*AW +: AW] = AW'(5);
    tick();
    rden = '0; wren[0] = 1'b1; waddr[0*AW +: AW] = AW'(5); wdata[0*DW +: DW] = DW'(12'hABC);
    tick();
    wren = '0;
    tick();
    req = '0;
    repeat (5) tick();
    req = 4'b0001; rden[0] = 1'b1; raddr[0*AW +: AW] = AW'(5);
    repeat (2) tick();
    idle_inputs();
    repeat (5) tick();

    // Non-owner enables are masked.
    req = 4'b0010;
    tick();
    wren = 4'b0011; rden = 4'b1000;
    wdata[0*DW +: DW] = DW'(12'hFFF); waddr[0*AW +: AW] = AW'(10'h3FF);
    wdata[1*DW +: DW] = DW'(12'h123); waddr[1*AW +: AW] = AW'(7);
    raddr[3*AW +: AW] = AW'(9);
    repeat (2) tick();
    idle_inputs();
    repeat (4) tick();

    // Read in the last GRANT cycle; a new requester must wait for the drain.
    req = 4'b0010;
    repeat (2) tick();
    rden[1] = 1'b1; raddr[1*AW +: AW] = AW'(9); req = 4'b0001;
    tick();
    rden = '0;
    repeat (6) tick();
    idle_inputs();
    repeat (5) tick();

    // Forced release after HOLD_MAX cycles; channel 0 is next.
    req = 4'b0100;
    tick();
    req = 4'b0101;
    repeat (HOLD_MAX + 6) tick();
    req = 4'b0100;
    repeat (4) tick();
    idle_inputs();
    repeat (5) tick();

    // Reset in the middle of GRANT with a read in flight.
    req = 4'b0100;
    tick();
    wren[2] = 1'b1; rden[2] = 1'b1; waddr[2*AW +: AW] = AW'(3); raddr[2*AW +: AW] = AW'(4);
    wdata[2*DW +: DW] = DW'(12'h5A5);
    tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_grant", 64'(grant), 64'(0));
    check("midrst_wren", 64'(commWren), 64'(0));
    check("midrst_rdvalid", 64'(rdValid), 64'(0));
    check("midrst_grantcnt", grantCnt, 64'(0));
    model_reset();
    idle_inputs();
    repeat (2) tick();
    reset = 1'b1;

    // All four requesting continuously, each dropping 3 cycles after its grant.
    req = 4'b1111;
    for (int t = 0; t < 30; t++) begin
      tick();
      for (int c = 0; c < 4; c++) if (c != m_owner) req[c] = 1'b1;
      if (m_owner >= 0 && cyc - m_gedge == 2) req[m_owner] = 1'b0;
    end
    idle_inputs();
    repeat (5) tick();

    // Randomized traffic.
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (req[c]) begin
          if ($urandom_range(0, 7) == 0) req[c] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[c] = 1'b1;
        end
        waddr[c*AW +: AW] = AW'($urandom_range(0, 15));
        raddr[c*AW +: AW] = AW'($urandom_range(0, 15));
        wdata[c*DW +: DW] = DW'($urandom);
      end
      wren = 4'($urandom);
      rden = 4'($urandom);
      tick();
    end
    idle_inputs();
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
